plot_move_sequencer: RTL and testbench
======================================

# plot_move_sequencer

Sequences straight-line plotter moves across the X and Y A4988 stepper drivers. It accepts one relative move command at a time (dx, dy, inverse_speed) over a valid/ready handshake. It then interpolates the line with a DDA and emits correctly timed STEP/DIR signals for both axes, tracking absolute position. It sits between the command front-end (G-code/path FSM) and the driver pins, and replaces free-running per-axis step clocks with coordinated, counted motion.

## Interface
- CLKS_PER_UNIT, 125000, clocks per step period for inverse_speed = 1 (2.5 ms at 50 MHz)
- PULSE_CLKS, 50, STEP high width in clocks (1 µs)
- DIR_SETUP_CLKS, 10, clocks from DIR change to first STEP rise (200 ns)
- clk  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  move command present
- cmd_ready  out  1  block idle, will accept command
- cmd_dx, cmd_dy  in  16  signed relative move, steps
- cmd_inverse_speed  in  16  period multiplier; 0 treated as 1
- abort  in  1  stop current move at next safe point
- step_x, step_y  out  1  STEP pins
- dir_x, dir_y  out  1  DIR pins, 1 = positive
- pos_x, pos_y  out  32  signed absolute position, steps
- busy  out  1  move in progress
- done  out  1  one-cycle pulse at move end (normal or aborted)

## Operation
- Reset values: cmd_ready 1 in the cycle after reset deasserts (0 while reset is high). step_x/y 0, dir_x/y 0, pos_x/y 0, busy 0, done 0, state IDLE.
- States: IDLE -> SETUP -> PULSE -> GAP -> (PULSE | IDLE).
- IDLE: cmd_ready = 1. Accept on cmd_valid && cmd_ready. Latch ax=|dx| and ay=|dy| (17 bit), n = max(ax, ay), and period = CLKS_PER_UNIT * max(inv_speed,1) as 33 bit unsigned. If period < 2*PULSE_CLKS, period = 2*PULSE_CLKS.
- On accept, dir_x is set to (dx > 0) only if dx != 0, and dir_y likewise; otherwise DIR holds its previous value. DIR is stable for the whole move and held after it.
- n = 0: go straight to IDLE. done pulses 1 cycle after accept. No STEP, no position change.
- SETUP: hold for DIR_SETUP_CLKS cycles, then enter PULSE.
- DDA: acc_x and acc_y are 17 bit, initialised to n>>1.
- On each PULSE entry: acc += a. If acc >= n, the axis steps and acc -= n. The major axis steps every iteration; the minor axis steps exactly a times over n iterations.
- PULSE: the stepping axes' STEP is high for PULSE_CLKS cycles. pos += ±1 in the first PULSE cycle, per dir.
- GAP: STEP low for period - PULSE_CLKS cycles. After iteration n, go to IDLE and pulse done; otherwise enter PULSE.
- abort while busy:
  - In SETUP or GAP: go to IDLE next cycle.
  - In PULSE: finish the full pulse width, then go to IDLE.
  - done pulses on the IDLE entry. abort in IDLE is ignored.
- busy = state != IDLE.
- Reset mid-move forces all reset values immediately, including pos.

## Timing
- Accept at cycle T. DIR valid at T+1. First STEP rise at T+1+DIR_SETUP_CLKS.
- Successive STEP rises of the major axis are exactly period cycles apart.
- Move duration, accept to done: 1 + DIR_SETUP_CLKS + n*period cycles. done is high in the first IDLE cycle; cmd_ready is high the same cycle.
- A back-to-back command can be accepted in the done cycle.
- All outputs are registered; no combinational path from inputs to STEP/DIR.

## Structure
- Shared package plotter_pkg holds:
  - the state enum {IDLE, SETUP, PULSE, GAP}
  - default CLKS_PER_UNIT, PULSE_CLKS and DIR_SETUP_CLKS
  - the 33-bit period width constant
- Sub-module axis_dda, instantiated for X and Y, contains:
  - accumulator, step decision, direction latch, pos counter and STEP register
  - controls: load, iterate and clear strobes from the sequencer FSM

## Test plan
Use CLKS_PER_UNIT = 4, PULSE_CLKS = 2, DIR_SETUP_CLKS = 1 for all scenarios.

- Move dx=5, dy=0, inv=1 (period=4): 5 step_x pulses, 4 cycles apart. step_y never rises. pos_x=5. done at T+1+1+20.
- Move dx=-3, dy=7, inv=2 (period=8):
  - 7 step_y pulses, 3 step_x pulses, each x pulse coincident with a y pulse.
  - dir_x=0, dir_y=1. Final pos = (-3, 7).
- Move dx=0, dy=0: no steps; done exactly 1 cycle after accept; dir unchanged.
- Move dx=10, inv=0: treated as inv=1 (period=4); first STEP rise at T+2.
- abort asserted mid-PULSE of step 3 of a 10-step move:
  - the pulse completes its full 2 cycles; done follows; pos_x=3.
  - the next command is accepted normally.
- reset asserted during GAP: all outputs reach reset values the next cycle, and pos returns to 0.

Source files
------------

// File: rtl/plotter_pkg.sv
// plotter_pkg: shared state encoding, timing defaults and helpers for the plot move sequencer.
package plotter_pkg;

   typedef enum logic [1:0] {IDLE, SETUP, PULSE, GAP} state_t;

   localparam int DEF_CLKS_PER_UNIT  = 125000;
   localparam int DEF_PULSE_CLKS     = 50;
   localparam int DEF_DIR_SETUP_CLKS = 10;
   localparam int PERIOD_W           = 33;

   // 17 bits so that |-32768| is representable
   function automatic logic [16:0] abs17(input logic [15:0] v);
      return v[15] ? -{1'b1, v} : {1'b0, v};
   endfunction

endpackage

// File: rtl/axis_dda.sv
// axis_dda: per-axis DDA accumulator, step decision, direction latch, position counter and STEP register.
module axis_dda
   import plotter_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_load,
   input  logic        i_iterate,
   input  logic        i_clear,
   input  logic [15:0] i_delta,
   input  logic [16:0] i_n,
   output logic        o_step,
   output logic        o_dir,
   output logic [31:0] o_pos
);

   logic [16:0] r_a;
   logic [16:0] r_acc;
   logic        r_step;
   logic        r_dir;
   logic [31:0] r_pos;
   logic [17:0] w_sum;
   logic        w_hit;

   assign w_sum = {1'b0, r_acc} + {1'b0, r_a};
   assign w_hit = w_sum >= {1'b0, i_n};

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_a    <= '0;
         r_acc  <= '0;
         r_step <= 1'b0;
         r_dir  <= 1'b0;
         r_pos  <= '0;
      end else begin
         if (i_load) begin
            r_a   <= abs17(i_delta);
            r_acc <= {1'b0, i_n[16:1]};
            if (i_delta != '0) r_dir <= !i_delta[15];
         end
         if (i_iterate) begin
            r_acc  <= w_hit ? 17'(w_sum - {1'b0, i_n}) : w_sum[16:0];
            r_step <= w_hit;
            if (w_hit) r_pos <= r_pos + (r_dir ? 32'd1 : '1);
         end
         if (i_clear) r_step <= 1'b0;
      end
   end

   assign o_step = r_step;
   assign o_dir  = r_dir;
   assign o_pos  = r_pos;

endmodule

// File: rtl/plot_move_sequencer.sv
// plot_move_sequencer: accepts relative line moves and drives coordinated, timed STEP/DIR pulses on X and Y.
module plot_move_sequencer
   import plotter_pkg::*;
#(
   parameter int CLKS_PER_UNIT  = DEF_CLKS_PER_UNIT,
   parameter int PULSE_CLKS     = DEF_PULSE_CLKS,
   parameter int DIR_SETUP_CLKS = DEF_DIR_SETUP_CLKS
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_cmd_valid,
   output logic        o_cmd_ready,
   input  logic [15:0] i_cmd_dx,
   input  logic [15:0] i_cmd_dy,
   input  logic [15:0] i_cmd_inverse_speed,
   input  logic        i_abort,
   output logic        o_step_x,
   output logic        o_step_y,
   output logic        o_dir_x,
   output logic        o_dir_y,
   output logic [31:0] o_pos_x,
   output logic [31:0] o_pos_y,
   output logic        o_busy,
   output logic        o_done
);

   localparam logic [PERIOD_W-1:0] PW         = PERIOD_W'(PULSE_CLKS);
   localparam logic [PERIOD_W-1:0] MIN_PERIOD = PERIOD_W'(2 * PULSE_CLKS);
   localparam logic [PERIOD_W-1:0] SETUP_M1   = PERIOD_W'(DIR_SETUP_CLKS - 1);

   state_t              r_state;
   logic [PERIOD_W-1:0] r_cnt;
   logic [PERIOD_W-1:0] r_period;
   logic [16:0]         r_n;
   logic [16:0]         r_iter;
   logic                r_ready;
   logic                r_busy;
   logic                r_done;
   logic                r_abort;
   logic [16:0]         w_ax;
   logic [16:0]         w_ay;
   logic [16:0]         w_n;
   logic [15:0]         w_inv;
   logic [PERIOD_W-1:0] w_prod;
   logic [PERIOD_W-1:0] w_period;
   logic                w_cnt0;
   logic                w_accept;
   logic                w_iter;
   logic                w_clear;
   logic                w_end;

   assign w_ax     = abs17(i_cmd_dx);
   assign w_ay     = abs17(i_cmd_dy);
   assign w_n      = w_ax > w_ay ? w_ax : w_ay;
   assign w_inv    = i_cmd_inverse_speed == '0 ? 16'd1 : i_cmd_inverse_speed;
   assign w_prod   = PERIOD_W'(CLKS_PER_UNIT) * PERIOD_W'(w_inv);
   assign w_period = w_prod < MIN_PERIOD ? MIN_PERIOD : w_prod;
   assign w_cnt0   = r_cnt == '0;
   assign w_accept = r_state == IDLE && r_ready && i_cmd_valid;
   assign w_iter   = !i_abort && w_cnt0 && (r_state == SETUP || (r_state == GAP && r_iter != r_n));
   assign w_clear  = r_state == PULSE && w_cnt0;
   // an abort during PULSE is remembered so the pulse still completes its full width
   assign w_end    = ((r_state == SETUP || r_state == GAP) && i_abort)
                   || (r_state == GAP && w_cnt0 && r_iter == r_n)
                   || (w_clear && (r_abort || i_abort));

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_period <= '0;
         r_n      <= '0;
         r_iter   <= '0;
         r_ready  <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_abort  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_end) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_abort <= 1'b0;
         end else if (r_state == IDLE) begin
            r_ready <= 1'b1;
            if (w_accept) begin
               r_n      <= w_n;
               r_period <= w_period;
               r_iter   <= '0;
               r_cnt    <= SETUP_M1;
               r_done   <= w_n == '0;
               if (w_n != '0) begin
                  r_state <= SETUP;
                  r_ready <= 1'b0;
                  r_busy  <= 1'b1;
               end
            end
         end else begin
            r_abort <= r_abort | (r_state == PULSE && i_abort);
            if (w_iter) begin
               r_state <= PULSE;
               r_cnt   <= PW - 1'b1;
               r_iter  <= r_iter + 17'd1;
            end else if (w_clear) begin
               r_state <= GAP;
               r_cnt   <= r_period - PW - 1'b1;
            end else begin
               r_cnt <= r_cnt - 1'b1;
            end
         end
      end
   end

   axis_dda u_x (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_load    (w_accept),
      .i_iterate (w_iter),
      .i_clear   (w_clear),
      .i_delta   (i_cmd_dx),
      .i_n       (w_accept ? w_n : r_n),
      .o_step    (o_step_x),
      .o_dir     (o_dir_x),
      .o_pos     (o_pos_x)
   );

   axis_dda u_y (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_load    (w_accept),
      .i_iterate (w_iter),
      .i_clear   (w_clear),
      .i_delta   (i_cmd_dy),
      .i_n       (w_accept ? w_n : r_n),
      .o_step    (o_step_y),
      .o_dir     (o_dir_y),
      .o_pos     (o_pos_y)
   );

   assign o_cmd_ready = r_ready;
   assign o_busy      = r_busy;
   assign o_done      = r_done;

endmodule

// File: tb/tb_plot_move_sequencer.sv
// tb_plot_move_sequencer: scenario tasks plus randomized moves checked against a closed-form line-stepping model.
module tb_plot_move_sequencer;

   localparam int CPU = 4;
   localparam int PW  = 2;
   localparam int DS  = 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_cmd_valid = 1'b0;
   logic [15:0] i_cmd_dx = '0;
   logic [15:0] i_cmd_dy = '0;
   logic [15:0] i_cmd_inv = '0;
   logic        i_abort = 1'b0;
   logic        o_cmd_ready, o_step_x, o_step_y, o_dir_x, o_dir_y, o_busy, o_done;
   logic [31:0] o_pos_x, o_pos_y;

   int total = 0;
   int bad = 0;
   int xr[$];
   int yr[$];
   int xw[$];
   int done_k;
   int exp_px = 0;
   int exp_py = 0;
   bit ed_x = 0;
   bit ed_y = 0;

   plot_move_sequencer #(.CLKS_PER_UNIT(CPU), .PULSE_CLKS(PW), .DIR_SETUP_CLKS(DS)) dut (
      .i_clk(clk), .i_reset(rst), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
      .i_cmd_dx(i_cmd_dx), .i_cmd_dy(i_cmd_dy), .i_cmd_inverse_speed(i_cmd_inv), .i_abort(i_abort),
      .o_step_x(o_step_x), .o_step_y(o_step_y), .o_dir_x(o_dir_x), .o_dir_y(o_dir_y),
      .o_pos_x(o_pos_x), .o_pos_y(o_pos_y), .o_busy(o_busy), .o_done(o_done)
   );

   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   function automatic int per_of(int inv);
      int p = CPU * (inv == 0 ? 1 : inv);
      return p < 2 * PW ? 2 * PW : p;
   endfunction

   // the minor axis has stepped floor((n/2 + i*a)/n) times after i iterations
   function automatic bit hits(int a, int n, int i);
      return ((n / 2 + i * a) / n) != ((n / 2 + (i - 1) * a) / n);
   endfunction

   function automatic int iabs(int v);
      return v < 0 ? -v : v;
   endfunction

   // drives one command and records STEP rise cycles relative to the accept cycle (0)
   task automatic do_move(input int dx, input int dy, input int inv, input int abort_at);
      int k, w;
      bit px, py, ab;
      xr.delete(); yr.delete(); xw.delete();
      done_k = -1; w = 0; ab = 0; k = 0;
      while (!o_cmd_ready && k < 20) begin @(negedge clk); k++; end
      i_cmd_dx = 16'(dx); i_cmd_dy = 16'(dy); i_cmd_inv = 16'(inv); i_cmd_valid = 1'b1;
      px = o_step_x; py = o_step_y;
      @(negedge clk);
      i_cmd_valid = 1'b0;
      for (k = 1; k < 4000; k++) begin
         if (o_step_x && !px) xr.push_back(k);
         if (o_step_y && !py) yr.push_back(k);
         if (o_step_x) w++;
         else if (px) begin xw.push_back(w); w = 0; end
         px = o_step_x; py = o_step_y;
         i_abort = 1'b0;
         if (abort_at > 0 && !ab && xr.size() == abort_at && o_step_x) begin i_abort = 1'b1; ab = 1; end
         if (o_done) begin done_k = k; break; end
         @(negedge clk);
      end
      i_abort = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (o_cmd_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", o_cmd_ready); end
      total++; if ({o_step_x, o_step_y, o_dir_x, o_dir_y, o_busy, o_done} !== 6'b0) begin bad++; $display("FAIL reset_ctl: got %b want 000000", {o_step_x, o_step_y, o_dir_x, o_dir_y, o_busy, o_done}); end
      total++; if ({o_pos_x, o_pos_y} !== 64'b0) begin bad++; $display("FAIL reset_pos: got %h want 0", {o_pos_x, o_pos_y}); end
      rst = 1'b0;
      @(negedge clk);
      total++; if (o_cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_after: got %b want 1", o_cmd_ready); end
   endtask

   task automatic test_x_only;
      bit ok = 1;
      do_move(5, 0, 1, 0);
      exp_px += 5; ed_x = 1;
      for (int i = 1; i < xr.size(); i++) if (xr[i] - xr[i-1] != 4) ok = 0;
      foreach (xw[i]) if (xw[i] != PW) ok = 0;
      total++; if (xr.size() != 5) begin bad++; $display("FAIL x_only_xcount: got %0d want 5", xr.size()); end
      total++; if (yr.size() != 0) begin bad++; $display("FAIL x_only_ycount: got %0d want 0", yr.size()); end
      total++; if (!ok) begin bad++; $display("FAIL x_only_spacing: got irregular want period 4 width 2"); end
      total++; if (done_k != 22) begin bad++; $display("FAIL x_only_done: got %0d want 22", done_k); end
      total++; if (o_pos_x !== 32'(exp_px) || o_dir_x !== 1'b1) begin bad++; $display("FAIL x_only_pos: got %0d/%b want %0d/1", $signed(o_pos_x), o_dir_x, exp_px); end
   endtask

   task automatic test_diag;
      int ex[$];
      bit ok = 1;
      do_move(-3, 7, 2, 0);
      exp_px -= 3; exp_py += 7; ed_x = 0; ed_y = 1;
      for (int i = 1; i <= 7; i++) if (hits(3, 7, i)) ex.push_back(1 + DS + (i - 1) * 8);
      if (xr.size() != ex.size()) ok = 0;
      else foreach (ex[i]) if (xr[i] != ex[i]) ok = 0;
      foreach (xr[i]) begin
         bit f = 0;
         foreach (yr[j]) if (yr[j] == xr[i]) f = 1;
         if (!f) ok = 0;
      end
      total++; if (yr.size() != 7) begin bad++; $display("FAIL diag_ycount: got %0d want 7", yr.size()); end
      total++; if (!ok) begin bad++; $display("FAIL diag_xpattern: got %0d x rises want %0d coincident with y", xr.size(), ex.size()); end
      total++; if (o_dir_x !== 1'b0 || o_dir_y !== 1'b1) begin bad++; $display("FAIL diag_dir: got %b%b want 01", o_dir_x, o_dir_y); end
      total++; if (o_pos_x !== 32'(exp_px) || o_pos_y !== 32'(exp_py)) begin bad++; $display("FAIL diag_pos: got %0d,%0d want %0d,%0d", $signed(o_pos_x), $signed(o_pos_y), exp_px, exp_py); end
      total++; if (done_k != 58) begin bad++; $display("FAIL diag_done: got %0d want 58", done_k); end
   endtask

   task automatic test_zero;
      do_move(0, 0, 1, 0);
      total++; if (done_k != 1) begin bad++; $display("FAIL zero_done: got %0d want 1", done_k); end
      total++; if (xr.size() + yr.size() != 0) begin bad++; $display("FAIL zero_steps: got %0d want 0", xr.size() + yr.size()); end
      total++; if (o_dir_x !== ed_x || o_dir_y !== ed_y) begin bad++; $display("FAIL zero_dir: got %b%b want %b%b", o_dir_x, o_dir_y, ed_x, ed_y); end
      total++; if (o_pos_x !== 32'(exp_px) || o_pos_y !== 32'(exp_py)) begin bad++; $display("FAIL zero_pos: got %0d,%0d want %0d,%0d", $signed(o_pos_x), $signed(o_pos_y), exp_px, exp_py); end
   endtask

   task automatic test_inv0;
      bit ok = 1;
      do_move(10, 0, 0, 0);
      exp_px += 10; ed_x = 1;
      for (int i = 1; i < xr.size(); i++) if (xr[i] - xr[i-1] != 4) ok = 0;
      total++; if (xr.size() == 0 || xr[0] != 2) begin bad++; $display("FAIL inv0_first: got %0d want 2", xr.size() ? xr[0] : -1); end
      total++; if (!ok || xr.size() != 10) begin bad++; $display("FAIL inv0_spacing: got %0d rises want 10 at period 4", xr.size()); end
      total++; if (done_k != 42) begin bad++; $display("FAIL inv0_done: got %0d want 42", done_k); end
   endtask

   task automatic test_abort;
      do_move(10, 0, 1, 3);
      exp_px += 3;
      total++; if (xr.size() != 3) begin bad++; $display("FAIL abort_count: got %0d want 3", xr.size()); end
      total++; if (xw.size() != 3 || xw[2] != PW) begin bad++; $display("FAIL abort_width: got %0d pulses want 3 of width %0d", xw.size(), PW); end
      total++; if (done_k != 12) begin bad++; $display("FAIL abort_done: got %0d want 12", done_k); end
      total++; if (o_pos_x !== 32'(exp_px)) begin bad++; $display("FAIL abort_pos: got %0d want %0d", $signed(o_pos_x), exp_px); end
      do_move(-2, 1, 1, 0);
      exp_px -= 2; exp_py += 1; ed_x = 0; ed_y = 1;
      total++; if (done_k != 10 || o_pos_x !== 32'(exp_px) || o_pos_y !== 32'(exp_py)) begin bad++; $display("FAIL abort_next: got done %0d pos %0d,%0d want 10 %0d,%0d", done_k, $signed(o_pos_x), $signed(o_pos_y), exp_px, exp_py); end
   endtask

   task automatic test_back_to_back;
      int dq[$];
      bit b11 = 0;
      while (!o_cmd_ready) @(negedge clk);
      i_cmd_dx = 16'd2; i_cmd_dy = 16'd0; i_cmd_inv = 16'd1; i_cmd_valid = 1'b1;
      @(negedge clk);
      i_cmd_dx = 16'hFFFF; i_cmd_dy = 16'd3;
      for (int k = 1; k <= 40; k++) begin
         if (o_done) dq.push_back(k);
         if (k == 11) begin b11 = o_busy; i_cmd_valid = 1'b0; end
         @(negedge clk);
      end
      exp_px += 1; exp_py += 3; ed_x = 0; ed_y = 1;
      total++; if (dq.size() != 2 || dq[0] != 10 || dq[1] != 24) begin bad++; $display("FAIL b2b_done: got %0d dones first %0d want 10 and 24", dq.size(), dq.size() ? dq[0] : -1); end
      total++; if (b11 !== 1'b1) begin bad++; $display("FAIL b2b_busy: got %b want 1", b11); end
      total++; if (o_pos_x !== 32'(exp_px) || o_pos_y !== 32'(exp_py)) begin bad++; $display("FAIL b2b_pos: got %0d,%0d want %0d,%0d", $signed(o_pos_x), $signed(o_pos_y), exp_px, exp_py); end
   endtask

   task automatic test_random;
      for (int m = 0; m < 14; m++) begin
         int dx = int'($urandom_range(12)) - 6;
         int dy = int'($urandom_range(12)) - 6;
         int inv = int'($urandom_range(2));
         int per = per_of(inv);
         int n = iabs(dx) > iabs(dy) ? iabs(dx) : iabs(dy);
         int ex[$];
         int ey[$];
         bit okx, oky;
         do_move(dx, dy, inv, 0);
         for (int i = 1; i <= n; i++) begin
            if (hits(iabs(dx), n, i)) ex.push_back(1 + DS + (i - 1) * per);
            if (hits(iabs(dy), n, i)) ey.push_back(1 + DS + (i - 1) * per);
         end
         exp_px += dx; exp_py += dy;
         if (dx != 0) ed_x = dx > 0;
         if (dy != 0) ed_y = dy > 0;
         okx = xr.size() == ex.size();
         if (okx) foreach (ex[i]) if (xr[i] != ex[i]) okx = 0;
         oky = yr.size() == ey.size();
         if (oky) foreach (ey[i]) if (yr[i] != ey[i]) oky = 0;
         total++; if (done_k != (n == 0 ? 1 : 1 + DS + n * per)) begin bad++; $display("FAIL rand%0d_done: got %0d want %0d (dx=%0d dy=%0d inv=%0d)", m, done_k, n == 0 ? 1 : 1 + DS + n * per, dx, dy, inv); end
         total++; if (!okx || !oky) begin bad++; $display("FAIL rand%0d_steps: got %0d/%0d rises want %0d/%0d at model times", m, xr.size(), yr.size(), ex.size(), ey.size()); end
         total++; if (o_pos_x !== 32'(exp_px) || o_pos_y !== 32'(exp_py) || o_dir_x !== ed_x || o_dir_y !== ed_y) begin bad++; $display("FAIL rand%0d_state: got %0d,%0d dir %b%b want %0d,%0d dir %b%b", m, $signed(o_pos_x), $signed(o_pos_y), o_dir_x, o_dir_y, exp_px, exp_py, ed_x, ed_y); end
      end
   endtask

   task automatic test_reset_mid;
      while (!o_cmd_ready) @(negedge clk);
      i_cmd_dx = 16'd10; i_cmd_dy = 16'd0; i_cmd_inv = 16'd1; i_cmd_valid = 1'b1;
      @(negedge clk);
      i_cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (o_busy !== 1'b1 || o_step_x !== 1'b0 || o_pos_x !== 32'(exp_px + 1)) begin bad++; $display("FAIL rmid_gap: got busy %b step %b pos %0d want 1 0 %0d", o_busy, o_step_x, $signed(o_pos_x), exp_px + 1); end
      rst = 1'b1;
      @(negedge clk);
      exp_px = 0; exp_py = 0; ed_x = 0; ed_y = 0;
      total++; if ({o_cmd_ready, o_step_x, o_step_y, o_dir_x, o_dir_y, o_busy, o_done} !== 7'b0) begin bad++; $display("FAIL rmid_ctl: got %b want 0000000", {o_cmd_ready, o_step_x, o_step_y, o_dir_x, o_dir_y, o_busy, o_done}); end
      total++; if ({o_pos_x, o_pos_y} !== 64'b0) begin bad++; $display("FAIL rmid_pos: got %0d,%0d want 0,0", $signed(o_pos_x), $signed(o_pos_y)); end
      rst = 1'b0;
      @(negedge clk);
      do_move(1, -1, 1, 0);
      exp_px = 1; exp_py = -1;
      total++; if (done_k != 6 || o_pos_x !== 32'(exp_px) || o_pos_y !== 32'(exp_py)) begin bad++; $display("FAIL rmid_after: got done %0d pos %0d,%0d want 6 1,-1", done_k, $signed(o_pos_x), $signed(o_pos_y)); end
   endtask

   initial begin
      test_reset;
      test_x_only;
      test_diag;
      test_zero;
      test_inv0;
      test_abort;
      test_back_to_back;
      test_random;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
